// File: rtl/jtag_dtm_tap.sv
// jtag_dtm_tap: oversampled JTAG TAP with IDCODE/DTMCS/DMI/BYPASS DRs bridging DMI scans to a DM handshake
module jtag_dtm_tap #(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int ABITS = 6,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jtag_TCK,
  input  logic             jtag_TMS,
  input  logic             jtag_TDI,
  output logic             jtag_TDO,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op
);
  localparam int DW = ABITS + 34;
  localparam logic [DW-1:0] ONE = DW'(1);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;
  tap_e state, nxt;
  logic [SYNC_STG-1:0] tck_s, tms_s, tdi_s;
  logic tck_q, tck_rise, tck_fall, tms, tdi, shifting;
  logic is_idc, is_dtm, is_dmi, busy, accepted, resp_ok;
  logic [4:0] ir;
  logic [5:0] len;
  logic [1:0] dmistat;
  logic [ABITS-1:0] last_addr;
  logic [31:0] last_rdata, dtm_cap;
  logic [DW-1:0] shreg, sh_nxt, cap, top;
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_s <= '0;
      tms_s <= '0;
      tdi_s <= '0;
      tck_q <= 1'b0;
    end else begin
      tck_s <= {tck_s[SYNC_STG-2:0], jtag_TCK};
      tms_s <= {tms_s[SYNC_STG-2:0], jtag_TMS};
      tdi_s <= {tdi_s[SYNC_STG-2:0], jtag_TDI};
      tck_q <= tck_s[SYNC_STG-1];
    end
  end
  assign tck_rise = tck_s[SYNC_STG-1] & ~tck_q;
  assign tck_fall = ~tck_s[SYNC_STG-1] & tck_q;
  assign tms = tms_s[SYNC_STG-1];
  assign tdi = tdi_s[SYNC_STG-1];
  assign is_idc = ir == 5'h01;
  assign is_dtm = ir == 5'h10;
  assign is_dmi = ir == 5'h11;
  assign shifting = state == SH_IR || state == SH_DR;
  assign len = state == SH_IR ? 6'd5 : is_dmi ? 6'(DW) : (is_idc || is_dtm) ? 6'd32 : 6'd1;
  // TDI enters at the top of the active length; bits above it are don't-care
  assign top = ONE << (len - 6'd1);
  assign sh_nxt = ((shreg >> 1) & ~top) | (tdi ? top : '0);
  assign dtm_cap = {14'b0, 3'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};
  assign cap = is_dmi ? {last_addr, last_rdata, busy ? 2'd3 : dmistat} :
               is_idc ? DW'(IDCODE_VAL) : is_dtm ? DW'(dtm_cap) : '0;
  assign resp_ok = busy & dmi_resp_valid & (accepted | (dmi_req_valid & dmi_req_ready));
  always_comb begin
    nxt = state;
    case (state)
      TLR:    nxt = tms ? TLR : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PA_DR;
      PA_DR:  nxt = tms ? EX2_DR : PA_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PA_IR;
      PA_IR:  nxt = tms ? EX2_IR : PA_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TLR;
      ir <= 5'h01;
      shreg <= '0;
      jtag_TDO <= 1'b0;
      busy <= 1'b0;
      accepted <= 1'b0;
      dmistat <= 2'd0;
      last_addr <= '0;
      last_rdata <= '0;
      dmi_req_valid <= 1'b0;
      dmi_req_addr <= '0;
      dmi_req_data <= '0;
      dmi_req_op <= 2'd0;
    end else begin
      if (tck_rise) begin
        state <= nxt;
        shreg <= state == CAP_IR ? ONE : state == CAP_DR ? cap : shifting ? sh_nxt : shreg;
      end
      if (tck_fall) jtag_TDO <= shifting & shreg[0];
      if (tck_fall && state == UPD_IR) ir <= shreg[4:0];
      if (dmi_req_valid && dmi_req_ready) begin
        dmi_req_valid <= 1'b0;
        accepted <= 1'b1;
      end
      if (resp_ok) begin
        last_rdata <= dmi_resp_data;
        dmistat <= dmi_resp_op == 2'd2 ? 2'd2 : dmistat;
        busy <= 1'b0;
        accepted <= 1'b0;
      end
      // Update actions happen on the falling TCK edge inside Update-DR
      if (tck_fall && state == UPD_DR && is_dmi) begin
        if (busy) dmistat <= 2'd3;
        else if ((shreg[1:0] == 2'd1 || shreg[1:0] == 2'd2) && dmistat == 2'd0) begin
          dmi_req_addr <= shreg[DW-1:34];
          dmi_req_data <= shreg[33:2];
          dmi_req_op <= shreg[1:0];
          last_addr <= shreg[DW-1:34];
          dmi_req_valid <= 1'b1;
          busy <= 1'b1;
          accepted <= 1'b0;
        end
      end
      if (tck_fall && state == UPD_DR && is_dtm) begin
        if (shreg[16] || shreg[17]) dmistat <= 2'd0;
        if (shreg[17]) begin
          busy <= 1'b0;
          accepted <= 1'b0;
          dmi_req_valid <= 1'b0;
        end
      end
      if (state == TLR) begin
        ir <= 5'h01;
        busy <= 1'b0;
        accepted <= 1'b0;
        dmistat <= 2'd0;
        dmi_req_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jtag_dtm_tap.sv
// tb_jtag_dtm_tap: directed JTAG scans against the DTM with hand-computed expectations
module tb_jtag_dtm_tap;
  logic clk = 1'b0, rst = 1'b1;
  logic jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0, jtag_TDO;
  logic dmi_req_valid, dmi_req_ready = 1'b0;
  logic [5:0] dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0] dmi_req_op;
  logic dmi_resp_valid = 1'b0;
  logic [31:0] dmi_resp_data = '0;
  logic [1:0] dmi_resp_op = 2'd0;
  int total = 0, passed = 0;
  logic [39:0] o;
  logic x;
  jtag_dtm_tap dut (
    .clk(clk), .rst(rst), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI),
    .jtag_TDO(jtag_TDO), .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask
  task automatic tck(input logic m, input logic d, output logic q);
    jtag_TMS = m;
    jtag_TDI = d;
    #20;
    q = jtag_TDO;
    jtag_TCK = 1'b1;
    #40;
    jtag_TCK = 1'b0;
    #20;
  endtask
  task automatic scan(input logic is_ir, input logic [39:0] v, input int n, output logic [39:0] q);
    logic b;
    q = '0;
    tck(1'b1, 1'b0, b);
    if (is_ir) tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, v[i], b);
      q[i] = b;
    end
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask
  task automatic respond(input logic [31:0] d, input logic rdy);
    dmi_req_ready = rdy;
    dmi_resp_valid = 1'b1;
    dmi_resp_data = d;
    dmi_resp_op = 2'd0;
    #10;
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b0;
  endtask
  initial begin
    #50;
    chk("rst_tdo", jtag_TDO, 0);
    chk("rst_valid", dmi_req_valid, 0);
    chk("rst_addr", dmi_req_addr, 0);
    chk("rst_data", dmi_req_data, 0);
    chk("rst_op", dmi_req_op, 0);
    rst = 1'b0;
    #20;
    repeat (5) tck(1'b1, 1'b0, x);
    tck(1'b0, 1'b0, x);
    scan(1'b0, 40'h0, 32, o);
    chk("idcode", o[31:0], 32'h1000_0001);
    scan(1'b1, 40'h11, 5, o);
    chk("ir_capture", o[4:0], 5'b00001);
    scan(1'b0, 40'h0, 40, o);
    chk("dmi_initial", o, 40'h0);
    scan(1'b1, 40'h10, 5, o);
    scan(1'b0, 40'h0, 32, o);
    chk("dtmcs", o[31:0], 32'h0000_1061);
    scan(1'b1, 40'h11, 5, o);
    scan(1'b0, {6'h10, 32'h8001_0001, 2'b10}, 40, o);
    chk("wr_valid", dmi_req_valid, 1);
    chk("wr_addr", dmi_req_addr, 6'h10);
    chk("wr_data", dmi_req_data, 32'h8001_0001);
    chk("wr_op", dmi_req_op, 2'd2);
    #50;
    chk("hold_valid", dmi_req_valid, 1);
    chk("hold_addr", dmi_req_addr, 6'h10);
    chk("hold_data", dmi_req_data, 32'h8001_0001);
    chk("hold_op", dmi_req_op, 2'd2);
    dmi_req_ready = 1'b1;
    #10;
    dmi_req_ready = 1'b0;
    chk("wr_drop", dmi_req_valid, 0);
    respond(32'h1111_2222, 1'b0);
    scan(1'b0, {6'h11, 32'h0, 2'b01}, 40, o);
    chk("rd_valid", dmi_req_valid, 1);
    chk("rd_addr", dmi_req_addr, 6'h11);
    chk("rd_op", dmi_req_op, 2'd1);
    respond(32'hDEAD_BEEF, 1'b1);
    chk("rd_drop", dmi_req_valid, 0);
    scan(1'b0, 40'h0, 40, o);
    chk("rd_capture", o, {6'h11, 32'hDEAD_BEEF, 2'b00});
    scan(1'b0, {6'h05, 32'h0000_1234, 2'b10}, 40, o);
    chk("wr2_valid", dmi_req_valid, 1);
    dmi_req_ready = 1'b1;
    #10;
    dmi_req_ready = 1'b0;
    scan(1'b0, {6'h06, 32'h0000_5555, 2'b10}, 40, o);
    chk("busy_status", o[1:0], 2'd3);
    chk("busy_noreq", dmi_req_valid, 0);
    chk("busy_addr", dmi_req_addr, 6'h05);
    scan(1'b0, 40'h0, 40, o);
    chk("sticky_status", o[1:0], 2'd3);
    scan(1'b1, 40'h10, 5, o);
    scan(1'b0, 40'h0001_0000, 32, o);
    chk("dtmcs_sticky", o[31:0], 32'h0000_1C61);
    scan(1'b0, 40'h0, 32, o);
    chk("dtmcs_cleared", o[31:0], 32'h0000_1061);
    respond(32'hCAFE_F00D, 1'b0);
    #20;
    respond(32'hBAD0_0000, 1'b0);
    scan(1'b1, 40'h11, 5, o);
    scan(1'b0, 40'h0, 40, o);
    chk("resp_after_busy", o, {6'h05, 32'hCAFE_F00D, 2'b00});
    scan(1'b1, 40'h1F, 5, o);
    chk("bypass_ir", o[4:0], 5'b00001);
    scan(1'b0, 40'hB2, 8, o);
    chk("bypass_delay", o[7:0], 8'h64);
    scan(1'b1, 40'h11, 5, o);
    tck(1'b1, 1'b0, x);
    tck(1'b0, 1'b0, x);
    tck(1'b0, 1'b0, x);
    tck(1'b0, 1'b0, x);
    tck(1'b0, 1'b1, x);
    #20;
    chk("midscan_tdo", jtag_TDO, 1);
    rst = 1'b1;
    #30;
    rst = 1'b0;
    chk("midrst_tdo", jtag_TDO, 0);
    tck(1'b1, 1'b0, x);
    tck(1'b1, 1'b0, x);
    #100;
    chk("midrst_noreq", dmi_req_valid, 0);
    tck(1'b0, 1'b0, x);
    scan(1'b0, 40'h0, 32, o);
    chk("post_rst_idcode", o[31:0], 32'h1000_0001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
